mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/load_align.sv | 26 ++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access unit.
package mem_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BE_W          = 4;
  localparam int unsigned TMO_W         = 8;
  localparam int unsigned TIMEOUT_LIMIT = 255;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Byte enables for an access of the given size starting at byte lane off.
  function automatic logic [BE_W-1:0] be_mask(input size_e size, input logic [1:0] off);
    logic [BE_W-1:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m << off;
  endfunction

  // Replicate LSB-aligned store data across every lane the size can occupy.
  function automatic logic [DATA_W-1:0] store_lanes(input size_e size, input logic [DATA_W-1:0] data);
    logic [DATA_W-1:0] r;
    case (size)
      SZ_BYTE: r = {4{data[7:0]}};
      SZ_HALF: r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: lane shift then sign/zero extension.
module load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              zext,
  output logic [DATA_W-1:0] data_c
);

  logic [DATA_W-1:0] shifted_c;

  assign shifted_c = rdata >> {offset, 3'b000};

  always_comb begin
    data_c = '0;
    case (size)
      SZ_BYTE: data_c = {{24{~zext & shifted_c[7]}}, shifted_c[7:0]};
      SZ_HALF: data_c = {{16{~zext & shifted_c[15]}}, shifted_c[15:0]};
      SZ_WORD: data_c = shifted_c;
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data bus master: IDLE -> REQ -> DONE handshake with pipeline stall.
// Optional MEM_TIMEOUT_EN aborts a REQ that sees no ack within the timeout limit.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        MemRead_MEM,
  input  logic [3:0]        MemWrite_MEM,
  input  logic [DATA_W-1:0] ALU_Result_MEM,
  input  logic [DATA_W-1:0] write_data_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [BE_W-1:0]   dmem_be,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] read_data_MEM,
  output logic              mem_stall,
  output logic              misalign,
  output logic              bus_err
);

  logic              store_c;
  logic              pending_c;
  logic              misaligned_c;
  logic              tmo_hit_c;
  logic              unused_c;
  size_e             acc_size_c;
  logic [DATA_W-1:0] load_data_c;

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              zext_q, zext_d;
  logic              req_d, we_d, misalign_d;
  logic [BE_W-1:0]   be_d;
  logic [DATA_W-1:0] addr_d, wdata_d, rdata_d;

  // Store wins when both codes request an access; bit 3 of each code is reserved.
  assign store_c    = MemWrite_MEM[1:0] != 2'b00;
  assign acc_size_c = store_c ? size_e'(MemWrite_MEM[1:0]) : size_e'(MemRead_MEM[1:0]);
  assign pending_c  = acc_size_c != SZ_NONE;
  assign unused_c   = ^{MemRead_MEM[3], MemWrite_MEM[3:2]};

  always_comb begin
    case (acc_size_c)
      SZ_HALF: misaligned_c = ALU_Result_MEM[0];
      SZ_WORD: misaligned_c = |ALU_Result_MEM[1:0];
      default: misaligned_c = 1'b0;
    endcase
  end

  // Stall must rise in the same cycle the access is seen so the pipeline freezes.
  assign mem_stall = reset_n &
                     (((state_q == ST_IDLE) & pending_c & ~misaligned_c) | (state_q == ST_REQ));

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .size   (size_q),
    .zext   (zext_q),
    .data_c (load_data_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    off_d      = off_q;
    zext_d     = zext_q;
    req_d      = dmem_req;
    we_d       = dmem_we;
    be_d       = dmem_be;
    addr_d     = dmem_addr;
    wdata_d    = dmem_wdata;
    rdata_d    = read_data_MEM;
    misalign_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending_c && misaligned_c) begin
          misalign_d = 1'b1;
          rdata_d    = '0;
        end else if (pending_c) begin
          state_d = ST_REQ;
          size_d  = acc_size_c;
          off_d   = ALU_Result_MEM[1:0];
          zext_d  = MemRead_MEM[2];
          req_d   = 1'b1;
          we_d    = store_c;
          be_d    = be_mask(acc_size_c, ALU_Result_MEM[1:0]);
          addr_d  = {ALU_Result_MEM[DATA_W-1:2], 2'b00};
          wdata_d = store_lanes(acc_size_c, write_data_MEM);
        end
      end
      ST_REQ: begin
        if (dmem_ack || tmo_hit_c) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          addr_d  = '0;
          wdata_d = '0;
          if (tmo_hit_c) begin
            rdata_d = '0;
          end else if (!dmem_we) begin
            rdata_d = load_data_c;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      size_q        <= SZ_NONE;
      off_q         <= '0;
      zext_q        <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_be       <= '0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      read_data_MEM <= '0;
      misalign      <= 1'b0;
    end else begin
      state_q       <= state_d;
      size_q        <= size_d;
      off_q         <= off_d;
      zext_q        <= zext_d;
      dmem_req      <= req_d;
      dmem_we       <= we_d;
      dmem_be       <= be_d;
      dmem_addr     <= addr_d;
      dmem_wdata    <= wdata_d;
      read_data_MEM <= rdata_d;
      misalign      <= misalign_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  // tmo_q holds the number of REQ cycles already spent without ack.
  assign tmo_hit_c = (state_q == ST_REQ) && !dmem_ack &&
                     (tmo_q == TMO_W'(TIMEOUT_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tmo_q   <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo_hit_c;
      if (state_q == ST_REQ) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
    end
  end
`else
  assign tmo_hit_c = 1'b0;
  assign bus_err   = 1'b0;
`endif

endmodule
